func_table_scanner: RTL and testbench

- Sequencer that exhaustively exercises a combinational N-input boolean function unit, such as the team's 4-input function built on an 8:1 mux.
- Drives every input combination in ascending order, waits for settling, samples the unit's single output, and builds the measured truth table.
- Compares the measured table against an expected table latched at start and reports a mismatch count and the first failing index.
- Sits between a test/config controller and the function unit under exercise.

---
 rtl/func_table_scanner.sv | 134 +++++++++++++
 tb/tb_func_table_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/func_table_scanner.sv
// Truth-table scanner for a combinational N-input boolean function unit.
// Steps every input value, samples the output and compares to a latched table.
module func_table_scanner #(
    parameter int N_IN = 4,
    parameter int SETTLE_CYCLES = 1,
    localparam int TW = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TW-1:0]   expected,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_f,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   table_out,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx,
    output logic            mismatch
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int EW = N_IN + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [N_IN-1:0] LAST = N_IN'(TW - 1);
    localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);
    localparam logic [EW-1:0] ERR_ONE = EW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N_IN-1:0] idx;
    logic [CW-1:0] cnt;
    logic [TW-1:0] exp_q;
    logic hit_err;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign mismatch = (err_count != '0);
    assign hit_err = (dut_f != exp_q[idx]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort beats start and cancels any settle/sample step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort) state_d = IDLE;
                else if (cnt == CNT_ONE) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort) state_d = IDLE;
                else if (idx == LAST) state_d = DONE;
                else state_d = SETTLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan datapath: drive index, count settle time, record and score samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
            exp_q <= '0;
            dut_in <= '0;
            table_out <= '0;
            err_count <= '0;
            first_err_idx <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        exp_q <= expected;
                        idx <= '0;
                        dut_in <= '0;
                        cnt <= CNT_LOAD;
                        table_out <= '0;
                        err_count <= '0;
                        first_err_idx <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) dut_in <= '0;
                    else cnt <= cnt - CNT_ONE;
                end
                SAMPLE: begin
                    if (abort) begin
                        dut_in <= '0;
                    end else begin
                        table_out[idx] <= dut_f;
                        if (hit_err) begin
                            err_count <= err_count + ERR_ONE;
                            if (err_count == '0) first_err_idx <= idx;
                        end
                        if (idx != LAST) begin
                            idx <= idx + IDX_ONE;
                            dut_in <= idx + IDX_ONE;
                            cnt <= CNT_LOAD;
                        end
                    end
                end
                DONE: begin
                    dut_in <= '0;
                end
                default: dut_in <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_func_table_scanner.sv
// Bench for func_table_scanner: two instances (settle 1 and settle 3)
// checked every cycle against a cycle-offset model plus literal pins.
module tb_func_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic st [2];
    logic ab [2];
    logic [15:0] ex [2];
    logic [3:0] din [2];
    logic f [2];
    logic bsy [2];
    logic dn [2];
    logic [15:0] tab [2];
    logic [4:0] ec [2];
    logic [3:0] fe [2];
    logic mm [2];
    bit fm [2];

    int n_chk = 0;
    int n_fail = 0;

    // Unit under exercise: F=1 when ab == cd (0000, 0101, 1010, 1111)
    assign f[0] = fm[0] ? 1'b0 : (din[0][3:2] == din[0][1:0]);
    assign f[1] = fm[1] ? 1'b0 : (din[1][3:2] == din[1][1:0]);

    func_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
        .expected(ex[0]), .dut_in(din[0]), .dut_f(f[0]),
        .busy(bsy[0]), .done(dn[0]), .table_out(tab[0]),
        .err_count(ec[0]), .first_err_idx(fe[0]), .mismatch(mm[0])
    );

    func_table_scanner #(.N_IN(4), .SETTLE_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
        .expected(ex[1]), .dut_in(din[1]), .dut_f(f[1]),
        .busy(bsy[1]), .done(dn[1]), .table_out(tab[1]),
        .err_count(ec[1]), .first_err_idx(fe[1]), .mismatch(mm[1])
    );

    task automatic chk(string nm, int i, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, i, $time, a, e);
        end
    endtask

    function automatic int scyc(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic fval(int i, int j);
        logic [3:0] x;
        x = j[3:0];
        return fm[i] ? 1'b0 : (x[3:2] == x[1:0]);
    endfunction

    // Model: k = edges since acceptance; index j is sampled at edge (j+1)*(S+1)
    bit m_act [2];
    bit m_dc [2];
    int m_k [2];
    logic [15:0] m_lat [2];
    logic [15:0] m_tab [2];
    int m_err [2];
    int m_first [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 0;
                m_dc[i] = 0;
                m_k[i] = 0;
                m_lat[i] = '0;
                m_tab[i] = '0;
                m_err[i] = 0;
                m_first[i] = 0;
            end else if (m_dc[i]) begin
                m_dc[i] = 0;
            end else if (!m_act[i]) begin
                if (st[i] && !ab[i]) begin
                    m_act[i] = 1;
                    m_k[i] = 0;
                    m_lat[i] = ex[i];
                    m_tab[i] = '0;
                    m_err[i] = 0;
                    m_first[i] = 0;
                end
            end else if (ab[i]) begin
                m_act[i] = 0;
            end else begin
                int j;
                logic v;
                m_k[i]++;
                if (m_k[i] % (scyc(i) + 1) == 0) begin
                    j = m_k[i] / (scyc(i) + 1) - 1;
                    v = fval(i, j);
                    m_tab[i][j] = v;
                    if (v != m_lat[i][j]) begin
                        if (m_err[i] == 0) m_first[i] = j;
                        m_err[i]++;
                    end
                    if (j == 15) begin
                        m_act[i] = 0;
                        m_dc[i] = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int e_in;
                e_in = m_act[i] ? m_k[i] / (scyc(i) + 1) : (m_dc[i] ? 15 : 0);
                chk("busy", i, 32'(bsy[i]), 32'(m_act[i] || m_dc[i]));
                chk("done", i, 32'(dn[i]), 32'(m_dc[i]));
                chk("dut_in", i, 32'(din[i]), e_in);
                chk("table_out", i, 32'(tab[i]), 32'(m_tab[i]));
                chk("err_count", i, 32'(ec[i]), m_err[i]);
                chk("first_err_idx", i, 32'(fe[i]), m_first[i]);
                chk("mismatch", i, 32'(mm[i]), 32'(m_err[i] != 0));
            end
        end
    end

    task automatic run_scan(int i, logic [15:0] e, int edges, bit mid);
        int n;
        n = 0;
        @(negedge clk);
        st[i] = 1'b1;
        ex[i] = e;
        @(negedge clk);
        st[i] = 1'b0;
        ex[i] = ~e;
        while (!dn[i] && n < 400) begin
            @(negedge clk);
            n++;
            if (mid && n == 10) st[i] = 1'b1;
            if (mid && n == 11) st[i] = 1'b0;
        end
        chk("done_edge", i, n, edges);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
        chk("idle_after_done", i, 32'(bsy[i]), 0);
    endtask

    task automatic wait_in(int i, logic [3:0] v);
        int n;
        n = 0;
        while (din[i] !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_dut_in", i, 32'(din[i]), 32'(v));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            ab[i] = 1'b0;
            ex[i] = '0;
        end
        fm[0] = 0;
        fm[1] = 1;
        #23 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 0, 32'(bsy[0]), 0);

        run_scan(0, 16'h8421, 32, 0);
        chk("gold_table", 0, 32'(tab[0]), 32'h8421);
        chk("gold_err", 0, 32'(ec[0]), 0);
        chk("gold_mm", 0, 32'(mm[0]), 0);
        chk("gold_first", 0, 32'(fe[0]), 0);

        run_scan(0, 16'h8461, 32, 1);
        chk("one_table", 0, 32'(tab[0]), 32'h8421);
        chk("one_err", 0, 32'(ec[0]), 1);
        chk("one_first", 0, 32'(fe[0]), 6);
        chk("one_mm", 0, 32'(mm[0]), 1);

        run_scan(1, 16'h8421, 64, 0);
        chk("stuck_table", 1, 32'(tab[1]), 0);
        chk("stuck_err", 1, 32'(ec[1]), 4);
        chk("stuck_first", 1, 32'(fe[1]), 0);
        chk("stuck_mm", 1, 32'(mm[1]), 1);

        @(negedge clk);
        st[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        chk("abort_wins_idle", 0, 32'(bsy[0]), 0);

        @(negedge clk);
        st[0] = 1'b1;
        ex[0] = 16'h8421;
        @(negedge clk);
        st[0] = 1'b0;
        wait_in(0, 4'd5);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_busy", 0, 32'(bsy[0]), 0);
        chk("abort_done", 0, 32'(dn[0]), 0);
        chk("abort_dut_in", 0, 32'(din[0]), 0);
        chk("abort_table", 0, 32'(tab[0]), 32'h0001);
        repeat (40) @(negedge clk);
        chk("abort_hold", 0, 32'(tab[0]), 32'h0001);

        @(negedge clk);
        st[0] = 1'b1;
        ex[0] = 16'h8421;
        @(negedge clk);
        st[0] = 1'b0;
        wait_in(0, 4'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 0, 32'(bsy[0]), 0);
        chk("rst_done", 0, 32'(dn[0]), 0);
        chk("rst_dut_in", 0, 32'(din[0]), 0);
        chk("rst_table", 0, 32'(tab[0]), 0);
        chk("rst_err", 0, 32'(ec[0]), 0);
        chk("rst_first", 0, 32'(fe[0]), 0);
        chk("rst_mm", 0, 32'(mm[0]), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_scan(0, 16'h8421, 32, 0);
        chk("rescan_table", 0, 32'(tab[0]), 32'h8421);
        chk("rescan_err", 0, 32'(ec[0]), 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
